// File: rtl/recon_pkg.sv
// Shared types and constants for the intra-loop reconstruction sequencer.
package recon_pkg;

  typedef enum logic [2:0] {IDLE, EXTRACT, PREDICT, SAVE, DONE} seq_state_t;

  localparam logic [2:0] PH_EXTRACT = 3'b001;
  localparam logic [2:0] PH_PREDICT = 3'b010;
  localparam logic [2:0] PH_SAVE    = 3'b100;

  function automatic int unsigned num_mb(input int unsigned w, input int unsigned l);
    return (w / 4) * (l / 4);
  endfunction

endpackage

// File: rtl/recon_sequencer_if.sv
// Block handshake, saver feedback and phase/block-number bus of the reconstruction sequencer.
interface recon_sequencer_if;
  logic        start;
  logic        blk_valid;
  logic        blk_ready;
  logic        fb_luma4x4;
  logic        fb_chromab8x8;
  logic        fb_chromar8x8;
  logic [2:0]  enabler;
  logic [31:0] mbnumber_luma4x4;
  logic [31:0] mbnumber_chromab8x8;
  logic [31:0] mbnumber_chromar8x8;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, blk_valid, fb_luma4x4, fb_chromab8x8, fb_chromar8x8,
    output blk_ready, enabler, mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8,
    output busy, frame_done
  );

  modport slave (
    output start, blk_valid, fb_luma4x4, fb_chromab8x8, fb_chromar8x8,
    input  blk_ready, enabler, mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8,
    input  busy, frame_done
  );
endinterface

// File: rtl/recon_blk_counter.sv
// Luma 4x4 block index for the current frame, with clear/increment and last-block flag.
module recon_blk_counter #(
  parameter int unsigned NUM_MB = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count,
  output logic        last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

  assign last = (count == 32'(NUM_MB - 1));

endmodule

// File: rtl/recon_sequencer.sv
// Frame-level phase sequencer for the intra-loop reconstructor.
// Define RECON_SEQ_PERF_EN to add the stall_cycles/save_cycles performance counters.
module recon_sequencer
  import recon_pkg::*;
#(
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned LENGTH      = 720,
  parameter int unsigned EXTRACT_CYC = 1
) (
  input  logic                clk,
  input  logic                reset,
  recon_sequencer_if.master   bus
`ifdef RECON_SEQ_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         save_cycles
`endif
);

  localparam int unsigned NUM_MB   = num_mb(WIDTH, LENGTH);
  localparam logic [3:0]  EXT_LAST = 4'(EXTRACT_CYC - 1);

  seq_state_t  state_q;
  logic [2:0]  enabler_q;
  logic [3:0]  ph_cnt_q;
  logic        frame_done_q;

  logic        fb_all;
  logic        accept;
  logic        blk_clear;
  logic        blk_inc;
  logic        blk_last;
  logic [31:0] blk_num;

  // Feedbacks must coincide; staggered arrivals never complete a save.
  assign fb_all    = bus.fb_luma4x4 && bus.fb_chromab8x8 && bus.fb_chromar8x8;
  assign accept    = (state_q == PREDICT) && bus.blk_valid;
  assign blk_clear = (state_q == IDLE) && bus.start;
  assign blk_inc   = (state_q == SAVE) && fb_all && !blk_last;

  recon_blk_counter #(
    .NUM_MB (NUM_MB)
  ) u_blk_counter (
    .clk   (clk),
    .reset (reset),
    .clear (blk_clear),
    .inc   (blk_inc),
    .count (blk_num),
    .last  (blk_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      enabler_q    <= '0;
      ph_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= EXTRACT;
            enabler_q <= PH_EXTRACT;
            ph_cnt_q  <= '0;
          end
        end
        EXTRACT: begin
          if (ph_cnt_q == EXT_LAST) begin
            state_q   <= PREDICT;
            enabler_q <= PH_PREDICT;
            ph_cnt_q  <= '0;
          end else begin
            ph_cnt_q <= ph_cnt_q + 4'd1;
          end
        end
        PREDICT: begin
          if (accept) begin
            state_q   <= SAVE;
            enabler_q <= PH_SAVE;
          end
        end
        SAVE: begin
          if (fb_all) begin
            if (blk_last) begin
              state_q      <= DONE;
              enabler_q    <= '0;
              frame_done_q <= 1'b1;
            end else begin
              state_q   <= EXTRACT;
              enabler_q <= PH_EXTRACT;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          enabler_q <= '0;
        end
      endcase
    end
  end

  assign bus.blk_ready           = accept;
  assign bus.enabler             = enabler_q;
  assign bus.busy                = (state_q != IDLE);
  assign bus.frame_done          = frame_done_q;
  assign bus.mbnumber_luma4x4    = blk_num;
  assign bus.mbnumber_chromab8x8 = blk_num >> 2;
  assign bus.mbnumber_chromar8x8 = blk_num >> 2;

`ifdef RECON_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || blk_clear) begin
      stall_cycles <= '0;
      save_cycles  <= '0;
    end else begin
      if ((state_q == PREDICT) && !bus.blk_valid && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((state_q == SAVE) && !fb_all && (save_cycles != '1)) begin
        save_cycles <= save_cycles + 32'd1;
      end
    end
  end
`endif

  enabler_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(enabler_q));

endmodule

// File: tb/tb_recon_sequencer.sv
// Directed self-checking bench for recon_sequencer (16x8 frame, EXTRACT_CYC of 1 and 3).
module tb_recon_sequencer;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  recon_sequencer_if b1 ();
  recon_sequencer_if b3 ();

`ifdef RECON_SEQ_PERF_EN
  logic [31:0] stall1, save1, stall3, save3;
`endif

  recon_sequencer #(
    .WIDTH       (16),
    .LENGTH      (8),
    .EXTRACT_CYC (1)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .bus          (b1.master)
`ifdef RECON_SEQ_PERF_EN
    ,
    .stall_cycles (stall1),
    .save_cycles  (save1)
`endif
  );

  recon_sequencer #(
    .WIDTH       (16),
    .LENGTH      (8),
    .EXTRACT_CYC (3)
  ) dut3 (
    .clk          (clk),
    .reset        (reset),
    .bus          (b3.master)
`ifdef RECON_SEQ_PERF_EN
    ,
    .stall_cycles (stall3),
    .save_cycles  (save3)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_ph(input int k, input int ext);
    int r;
    r = k % (ext + 2);
    if (r < ext) return 3'b001;
    else if (r == ext) return 3'b010;
    else return 3'b100;
  endfunction

  task automatic set_fb1(input logic l, input logic b, input logic r);
    b1.fb_luma4x4    = l;
    b1.fb_chromab8x8 = b;
    b1.fb_chromar8x8 = r;
  endtask

  initial begin
    int fd_cnt;
    reset = 1'b1;
    b1.start = 1'b0; b1.blk_valid = 1'b0; set_fb1(1'b0, 1'b0, 1'b0);
    b3.start = 1'b0; b3.blk_valid = 1'b0;
    b3.fb_luma4x4 = 1'b0; b3.fb_chromab8x8 = 1'b0; b3.fb_chromar8x8 = 1'b0;
    step(); step();

    // Reset state
    check_eq("rst_enabler", 32'(b1.enabler), 32'd0);
    check_eq("rst_mb", b1.mbnumber_luma4x4, 32'd0);
    check_eq("rst_busy", 32'(b1.busy), 32'd0);
    check_eq("rst_done", 32'(b1.frame_done), 32'd0);
    reset = 1'b0;
    b1.blk_valid = 1'b1;
    #1;
    check_eq("rst_ready_idle", 32'(b1.blk_ready), 32'd0);

    // Full frame with immediate handshakes
    set_fb1(1'b1, 1'b1, 1'b1);
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check_eq($sformatf("f1_en%0d", k), 32'(b1.enabler), 32'(exp_ph(k, 1)));
      check_eq($sformatf("f1_mb%0d", k), b1.mbnumber_luma4x4, 32'(k / 3));
      check_eq($sformatf("f1_cb%0d", k), b1.mbnumber_chromab8x8, 32'((k / 3) >> 2));
      check_eq($sformatf("f1_cr%0d", k), b1.mbnumber_chromar8x8, 32'((k / 3) >> 2));
      check_eq($sformatf("f1_rdy%0d", k), 32'(b1.blk_ready), (k % 3 == 1) ? 32'd1 : 32'd0);
      check_eq($sformatf("f1_fd%0d", k), 32'(b1.frame_done), 32'd0);
      step();
    end
    check_eq("f1_done", 32'(b1.frame_done), 32'd1);
    check_eq("f1_done_en", 32'(b1.enabler), 32'd0);
    step();
    check_eq("f1_done_clr", 32'(b1.frame_done), 32'd0);
    check_eq("f1_idle_busy", 32'(b1.busy), 32'd0);
    check_eq("f1_mb_hold", b1.mbnumber_luma4x4, 32'd7);

    // Upstream stall of 5 cycles in block 2
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    check_eq("st_mb0", b1.mbnumber_luma4x4, 32'd0);
    repeat (6) step();
    check_eq("st_blk2_en", 32'(b1.enabler), 32'b001);
    check_eq("st_blk2_mb", b1.mbnumber_luma4x4, 32'd2);
    b1.blk_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("st_en%0d", i), 32'(b1.enabler), 32'b010);
      check_eq($sformatf("st_rdy%0d", i), 32'(b1.blk_ready), 32'd0);
      step();
    end
    b1.blk_valid = 1'b1;
    set_fb1(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("st_en6", 32'(b1.enabler), 32'b010);
    check_eq("st_rdy6", 32'(b1.blk_ready), 32'd1);
    step();
    check_eq("st_save_en", 32'(b1.enabler), 32'b100);
    check_eq("st_save_rdy", 32'(b1.blk_ready), 32'd0);
`ifdef RECON_SEQ_PERF_EN
    check_eq("perf_stall5", stall1, 32'd5);
`endif

    // Staggered feedbacks never complete the save
    set_fb1(1'b1, 1'b0, 1'b0);
    step();
    check_eq("fb_luma_only", 32'(b1.enabler), 32'b100);
    set_fb1(1'b0, 1'b1, 1'b0);
    step();
    check_eq("fb_chb_only", 32'(b1.enabler), 32'b100);
    set_fb1(1'b0, 1'b0, 1'b1);
    step();
    check_eq("fb_chr_only", 32'(b1.enabler), 32'b100);
    check_eq("fb_mb_held", b1.mbnumber_luma4x4, 32'd2);
    set_fb1(1'b1, 1'b1, 1'b1);
    step();
    check_eq("fb_all_en", 32'(b1.enabler), 32'b001);
    check_eq("fb_all_mb", b1.mbnumber_luma4x4, 32'd3);
`ifdef RECON_SEQ_PERF_EN
    check_eq("perf_save3", save1, 32'd3);
    check_eq("perf_stall_keep", stall1, 32'd5);
`endif

    // start mid-frame is ignored
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    check_eq("ms_en", 32'(b1.enabler), 32'b010);
    check_eq("ms_mb", b1.mbnumber_luma4x4, 32'd3);
    step(); step();
    check_eq("ms_next_mb", b1.mbnumber_luma4x4, 32'd4);
    check_eq("ms_next_en", 32'(b1.enabler), 32'b001);
    fd_cnt = 0;
    repeat (16) begin
      step();
      if (b1.frame_done) fd_cnt++;
    end
    check_eq("ms_done_count", 32'(fd_cnt), 32'd1);
    check_eq("ms_idle", 32'(b1.busy), 32'd0);

    // Reset while saving block 5
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    repeat (15) step();
    check_eq("rs_blk5_mb", b1.mbnumber_luma4x4, 32'd5);
    set_fb1(1'b0, 1'b0, 1'b0);
    step(); step();
    check_eq("rs_save_en", 32'(b1.enabler), 32'b100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rs_en", 32'(b1.enabler), 32'd0);
    check_eq("rs_busy", 32'(b1.busy), 32'd0);
    check_eq("rs_mb", b1.mbnumber_luma4x4, 32'd0);
    check_eq("rs_cb", b1.mbnumber_chromab8x8, 32'd0);
    check_eq("rs_done", 32'(b1.frame_done), 32'd0);
`ifdef RECON_SEQ_PERF_EN
    check_eq("rs_perf_stall", stall1, 32'd0);
    check_eq("rs_perf_save", save1, 32'd0);
`endif
    set_fb1(1'b1, 1'b1, 1'b1);
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    check_eq("rs_restart_en", 32'(b1.enabler), 32'b001);
    check_eq("rs_restart_mb", b1.mbnumber_luma4x4, 32'd0);
    check_eq("rs_restart_busy", 32'(b1.busy), 32'd1);

    // EXTRACT_CYC = 3: 5 cycles per block
    b3.blk_valid = 1'b1;
    b3.fb_luma4x4 = 1'b1; b3.fb_chromab8x8 = 1'b1; b3.fb_chromar8x8 = 1'b1;
    b3.start = 1'b1;
    step();
    b3.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("x3_en%0d", k), 32'(b3.enabler), 32'(exp_ph(k, 3)));
      check_eq($sformatf("x3_mb%0d", k), b3.mbnumber_luma4x4, 32'(k / 5));
      step();
    end
    repeat (29) step();
    check_eq("x3_last_save", 32'(b3.enabler), 32'b100);
    check_eq("x3_pre_done", 32'(b3.frame_done), 32'd0);
    step();
    check_eq("x3_done", 32'(b3.frame_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
